// File: rtl/eq_seq_pkg.sv
// Shared definitions for the per-sample equalizer sequencer:
// state encoding, channel slice positions and wait-counter sizing.
package eq_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      STROBE  = 3'd3,
      WAIT    = 3'd4,
      WRITE   = 3'd5
   } state_t;

   localparam int unsigned L_LSB = 0;

   // Right channel occupies the upper half of the stereo word.
   function automatic int unsigned r_lsb(input int unsigned sample_width);
      return sample_width;
   endfunction

   // The wait counter holds EQ_LATENCY-1 down to 0; keep at least one bit.
   function automatic int unsigned cnt_width(input int unsigned latency);
      return (latency <= 2) ? 1 : $clog2(latency);
   endfunction

endpackage

// File: rtl/eq_sample_sequencer.sv
// Moves one stereo sample at a time ADC FIFO -> equalizers -> DAC FIFO.
// Optional EQ_SEQ_BYPASS_EN adds a bypass input that routes the raw word straight to the DAC FIFO.
module eq_sample_sequencer
   import eq_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned EQ_LATENCY   = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    init_done,
`ifdef EQ_SEQ_BYPASS_EN
   input  logic                    bypass,
`endif
   input  logic                    adcfifo_empty,
   output logic                    adcfifo_read,
   input  logic [DATA_WIDTH-1:0]   adcfifo_readdata,
   input  logic                    dacfifo_full,
   output logic                    dacfifo_wren,
   output logic [DATA_WIDTH-1:0]   dacfifo_wrdata,
   output logic                    eq_ce,
   output logic [SAMPLE_WIDTH-1:0] eq_in_l,
   output logic [SAMPLE_WIDTH-1:0] eq_in_r,
   input  logic [SAMPLE_WIDTH-1:0] eq_out_l,
   input  logic [SAMPLE_WIDTH-1:0] eq_out_r,
   output logic                    busy,
   output logic [31:0]             sample_cnt
);

   localparam int unsigned CNT_W = cnt_width(EQ_LATENCY);
   localparam int unsigned R_LSB = r_lsb(SAMPLE_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EQ_LATENCY - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             cnt_done;
   logic             byp;

`ifdef EQ_SEQ_BYPASS_EN
   assign byp = bypass;
`else
   assign byp = 1'b0;
`endif

   assign cnt_done = (wait_cnt == '0);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (init_done && !adcfifo_empty && !dacfifo_full) begin
               state_nxt = READ;
            end
         end
         READ:    state_nxt = CAPTURE;
         CAPTURE: state_nxt = byp ? WRITE : STROBE;
         STROBE:  state_nxt = WAIT;
         WAIT: begin
            if (cnt_done) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (!dacfifo_full) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Moore strobes; the DAC push is qualified by full so a blocked write simply holds
   always_comb begin
      adcfifo_read = 1'b0;
      eq_ce        = 1'b0;
      dacfifo_wren = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE:    busy         = 1'b0;
         READ:    adcfifo_read = 1'b1;
         STROBE:  eq_ce        = 1'b1;
         WRITE:   dacfifo_wren = !dacfifo_full;
         default: ;
      endcase
   end

   // Sample capture, latency counter, result register and push counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eq_in_l        <= '0;
         eq_in_r        <= '0;
         wait_cnt       <= '0;
         dacfifo_wrdata <= '0;
         sample_cnt     <= '0;
      end else begin
         case (state)
            CAPTURE: begin
               eq_in_l <= adcfifo_readdata[L_LSB +: SAMPLE_WIDTH];
               eq_in_r <= adcfifo_readdata[R_LSB +: SAMPLE_WIDTH];
               if (byp) begin
                  dacfifo_wrdata <= adcfifo_readdata;
               end
            end
            STROBE: wait_cnt <= CNT_LOAD;
            WAIT: begin
               if (cnt_done) begin
                  dacfifo_wrdata <= DATA_WIDTH'({eq_out_r, eq_out_l});
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            WRITE: begin
               if (!dacfifo_full) begin
                  sample_cnt <= sample_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eq_sample_sequencer.sv
// Directed bench for eq_sample_sequencer with ADC FIFO, equalizer and DAC monitor models.
// Build with EQ_SEQ_BYPASS_EN to also exercise the bypass path.
module tb_eq_sample_sequencer;

   localparam int unsigned DW = 32;
   localparam int unsigned SW = 16;
   localparam int unsigned L  = 8;

   logic          clk;
   logic          reset_n;
   logic          init_done;
   logic          adcfifo_empty;
   logic          adcfifo_read;
   logic [DW-1:0] adcfifo_readdata;
   logic          dacfifo_full;
   logic          dacfifo_wren;
   logic [DW-1:0] dacfifo_wrdata;
   logic          eq_ce;
   logic [SW-1:0] eq_in_l;
   logic [SW-1:0] eq_in_r;
   logic [SW-1:0] eq_out_l;
   logic [SW-1:0] eq_out_r;
   logic          busy;
   logic [31:0]   sample_cnt;
`ifdef EQ_SEQ_BYPASS_EN
   logic          bypass;
`endif

   eq_sample_sequencer #(
      .DATA_WIDTH  (DW),
      .SAMPLE_WIDTH(SW),
      .EQ_LATENCY  (L)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .init_done       (init_done),
`ifdef EQ_SEQ_BYPASS_EN
      .bypass          (bypass),
`endif
      .adcfifo_empty   (adcfifo_empty),
      .adcfifo_read    (adcfifo_read),
      .adcfifo_readdata(adcfifo_readdata),
      .dacfifo_full    (dacfifo_full),
      .dacfifo_wren    (dacfifo_wren),
      .dacfifo_wrdata  (dacfifo_wrdata),
      .eq_ce           (eq_ce),
      .eq_in_l         (eq_in_l),
      .eq_in_r         (eq_in_r),
      .eq_out_l        (eq_out_l),
      .eq_out_r        (eq_out_r),
      .busy            (busy),
      .sample_cnt      (sample_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ADC FIFO model: pop on read, data visible the following cycle
   logic [DW-1:0] adc_mem [0:127];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic          gap    = 1'b0;

   assign adcfifo_empty = (rd_ptr == wr_ptr) || gap;

   always @(posedge clk) begin
      if (adcfifo_read) begin
         adcfifo_readdata <= adc_mem[rd_ptr];
         rd_ptr           <= rd_ptr + 1;
      end
   end

   task automatic adc_push(input logic [DW-1:0] w);
      adc_mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   // Equalizer model: result = input ^ eq_xor, valid exactly L cycles after the strobe
   logic [SW-1:0] eq_xor = '0;
   logic [SW-1:0] pend_l, pend_r;
   int            dly = 0;

   always @(posedge clk) begin
      if (eq_ce) begin
         pend_l   <= eq_in_l ^ eq_xor;
         pend_r   <= eq_in_r ^ eq_xor;
         eq_out_l <= 16'hDEAD;
         eq_out_r <= 16'hDEAD;
         dly      <= L - 1;
      end else if (dly > 0) begin
         dly <= dly - 1;
         if (dly == 1) begin
            eq_out_l <= pend_l;
            eq_out_r <= pend_r;
         end
      end
   end

   // Monitor: cycle stamps of reads and pushes, strobe count
   int            cyc     = 0;
   int            rd_n    = 0;
   int            ce_n    = 0;
   int            dac_cnt = 0;
   int            rd_t    [0:127];
   int            dac_t   [0:127];
   logic [DW-1:0] dac_mem [0:127];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (adcfifo_read) begin
         rd_t[rd_n] <= cyc;
         rd_n       <= rd_n + 1;
      end
      if (eq_ce) ce_n <= ce_n + 1;
      if (dacfifo_wren) begin
         dac_mem[dac_cnt] <= dacfifo_wrdata;
         dac_t[dac_cnt]   <= cyc;
         dac_cnt          <= dac_cnt + 1;
      end
   end

   task automatic wait_push(input int target, input string tag);
      int n = 0;
      while (dac_cnt < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(dac_cnt), 32'(target));
   endtask

   task automatic wait_read(input int target, input string tag);
      int n = 0;
      while (rd_n < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(rd_n), 32'(target));
   endtask

   logic [DW-1:0] exp_w [0:49];

   initial begin
      int            base, rd_base, ce_base, min_gap, n;
      logic          busy_seen, wren_seen;
      logic [DW-1:0] held;

      reset_n      = 1'b0;
      init_done    = 1'b0;
      dacfifo_full = 1'b0;
`ifdef EQ_SEQ_BYPASS_EN
      bypass       = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_read", 32'(adcfifo_read), 32'd0);
      check("rst_ce", 32'(eq_ce), 32'd0);
      check("rst_wren", 32'(dacfifo_wren), 32'd0);
      check("rst_wrdata", dacfifo_wrdata, 32'd0);
      check("rst_cnt", sample_cnt, 32'd0);
      check("rst_eq_in", 32'({eq_in_r, eq_in_l}), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single sample, identity equalizer
      adc_push(32'h1234_ABCD);
      init_done = 1'b1;
      wait_push(1, "t1_push_timeout");
      check("t1_wrdata", dac_mem[0], 32'h1234_ABCD);
      check("t1_latency", 32'(dac_t[0] - rd_t[0]), 32'd11);
      check("t1_ce_pulses", 32'(ce_n), 32'd1);
      check("t1_eq_in_l", 32'(eq_in_l), 32'h0000_ABCD);
      check("t1_eq_in_r", 32'(eq_in_r), 32'h0000_1234);
      @(negedge clk);
      check("t1_sample_cnt", sample_cnt, 32'd1);
      check("t1_idle", 32'(busy), 32'd0);

      // init_done low: a waiting word must not be read
      init_done = 1'b0;
      adc_push(32'h5555_AAAA);
      busy_seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (busy || adcfifo_read) busy_seen = 1'b1;
      end
      check("t2_no_read", 32'(rd_n), 32'd1);
      check("t2_busy", 32'(busy_seen), 32'd0);

      // DAC FIFO full while the result waits in WRITE
      init_done = 1'b1;
      wait_read(2, "t3_read_timeout");
      dacfifo_full = 1'b1;
      repeat (15) @(negedge clk);
      held      = dacfifo_wrdata;
      wren_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (dacfifo_wren || dacfifo_wrdata !== held) wren_seen = 1'b1;
      end
      check("t3_held_data", held, 32'h5555_AAAA);
      check("t3_no_wren_or_change", 32'(wren_seen), 32'd0);
      check("t3_no_push_while_full", 32'(dac_cnt), 32'd1);
      check("t3_busy_while_full", 32'(busy), 32'd1);
      dacfifo_full = 1'b0;
      repeat (5) @(negedge clk);
      check("t3_single_push", 32'(dac_cnt), 32'd2);
      check("t3_pushed_data", dac_mem[1], 32'h5555_AAAA);
      check("t3_sample_cnt", sample_cnt, 32'd2);

      // Stream of 50 words with random empty gaps, non-identity equalizer
      eq_xor  = 16'h00FF;
      base    = dac_cnt;
      rd_base = rd_n;
      ce_base = ce_n;
      for (int i = 0; i < 50; i++) begin
         logic [SW-1:0] wl, wr;
         wl = 16'(16'hF000 - i * 113);
         wr = 16'(16'h0100 + i * 37);
         adc_push({wr, wl});
         exp_w[i] = {wr ^ 16'h00FF, wl ^ 16'h00FF};
      end
      n = 0;
      while (dac_cnt < base + 50 && n < 5000) begin
         @(negedge clk);
         gap = ($urandom_range(0, 3) == 0);
         n++;
      end
      gap = 1'b0;
      check("t4_push_count", 32'(dac_cnt - base), 32'd50);
      for (int i = 0; i < 50; i++) begin
         check($sformatf("t4_word%0d", i), dac_mem[base + i], exp_w[i]);
      end
      check("t4_ce_pulses", 32'(ce_n - ce_base), 32'd50);
      @(negedge clk);
      check("t4_sample_cnt", sample_cnt, 32'd52);
      min_gap = 1000;
      for (int k = rd_base + 1; k < rd_base + 50; k++) begin
         if (rd_t[k] - rd_t[k-1] < min_gap) min_gap = rd_t[k] - rd_t[k-1];
      end
      check("t4_read_spacing_ok", 32'(min_gap >= int'(L + 4)), 32'd1);

      // Reset during WAIT aborts the in-flight word
      eq_xor = '0;
      base   = dac_cnt;
      adc_push(32'hDEAD_BEEF);
      adc_push(32'h0BAD_F00D);
      wait_read(rd_base + 51, "t5_read_timeout");
      repeat (5) @(negedge clk);
      check("t5_in_wait", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_ce", 32'(eq_ce), 32'd0);
      check("t5_rst_wren", 32'(dacfifo_wren), 32'd0);
      check("t5_rst_wrdata", dacfifo_wrdata, 32'd0);
      check("t5_rst_cnt", sample_cnt, 32'd0);
      check("t5_rst_eq_in", 32'({eq_in_r, eq_in_l}), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_push(base + 1, "t5_push_timeout");
      check("t5_next_word", dac_mem[base], 32'h0BAD_F00D);
      @(negedge clk);
      check("t5_sample_cnt", sample_cnt, 32'd1);
      repeat (20) @(negedge clk);
      check("t5_no_abort_push", 32'(dac_cnt - base), 32'd1);

`ifdef EQ_SEQ_BYPASS_EN
      // Bypass: raw word pushed straight after capture, no strobe
      bypass  = 1'b1;
      base    = dac_cnt;
      rd_base = rd_n;
      ce_base = ce_n;
      adc_push(32'h0001_FFFF);
      wait_push(base + 1, "t6_push_timeout");
      check("t6_wrdata", dac_mem[base], 32'h0001_FFFF);
      check("t6_latency", 32'(dac_t[base] - rd_t[rd_base]), 32'd2);
      check("t6_no_ce", 32'(ce_n - ce_base), 32'd0);
      bypass = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
